dmem_ctrl: RTL and testbench

Sequencing controller and two-way arbiter in front of the word-wide data RAM. It shares the RAM between the core load/store unit (port C) and the program/data loader (port L). It also turns RV32 sub-word accesses (LB/LH/LBU/LHU/SB/SH) into word operations: loads are extracted and extended, and sub-word stores become two-cycle read-modify-write sequences. It sits between the LSU/loader and the RAM's `we/addr/din/dout` pins.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: RV32 size codes, FSM states
// and arbiter port ids.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane handling for core accesses: load extraction with sign/zero
// extension, store-word merge, and alignment checking.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_o       = '0;
    merge_o      = word_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        load_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H, F3_HU: begin
        misaligned_o = addr_lo_i[0];
        load_o = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      F3_W: begin
        misaligned_o = |addr_lo_i;
        load_o       = word_i;
        merge_o      = wdata_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin arbiter and access sequencer in front of the word-wide data RAM;
// sub-word core stores become a read cycle followed by a MERGE write cycle.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [2:0]    c_funct3,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  state_e        state_q, state_d;
  port_e         last_q, last_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [31:0]   mdata_q, mdata_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          c_err_q, c_err_d;
  logic [31:0]   c_rdata_q, c_rdata_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [31:0]   l_rdata_q, l_rdata_d;

  logic [31:0]   c_load, c_merge;
  logic          c_mis;
  logic [AW-1:0] c_word_addr, l_word_addr;
  logic          l_addr_lo_unused;

  assign c_word_addr      = {c_addr[AW-1:2], 2'b00};
  assign l_word_addr      = {l_addr[AW-1:2], 2'b00};
  assign l_addr_lo_unused = &l_addr[1:0];

  dmem_lane_align u_align (
    .funct3_i     (c_funct3),
    .addr_lo_i    (c_addr[1:0]),
    .word_i       (mem_dout),
    .wdata_i      (c_wdata),
    .load_o       (c_load),
    .merge_o      (c_merge),
    .misaligned_o (c_mis)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    maddr_d    = maddr_q;
    mdata_d    = mdata_q;
    c_rvalid_d = 1'b0;
    c_err_d    = 1'b0;
    c_rdata_d  = c_rdata_q;
    l_rvalid_d = 1'b0;
    l_rdata_d  = l_rdata_q;
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;

    if (state_q == ST_MERGE) begin
      mem_we   = 1'b1;
      mem_addr = maddr_q;
      mem_din  = mdata_q;
      state_d  = ST_IDLE;
    end else if (!rst) begin
      // Grants stay low while reset is held so every output reads zero.
      c_gnt = c_req && (!l_req || last_q == PORT_L);
      l_gnt = l_req && !c_gnt;

      if (c_gnt) begin
        last_d = PORT_C;
        if (c_mis) begin
          c_rvalid_d = 1'b1;
          c_err_d    = 1'b1;
          c_rdata_d  = '0;
        end else if (!c_we) begin
          mem_addr   = c_word_addr;
          c_rvalid_d = 1'b1;
          c_rdata_d  = c_load;
        end else if (c_funct3 == F3_W) begin
          mem_we   = 1'b1;
          mem_addr = c_word_addr;
          mem_din  = c_wdata;
        end else begin
          mem_addr = c_word_addr;
          maddr_d  = c_word_addr;
          mdata_d  = c_merge;
          state_d  = ST_MERGE;
        end
      end else if (l_gnt) begin
        last_d   = PORT_L;
        mem_addr = l_word_addr;
        if (l_we) begin
          mem_we  = 1'b1;
          mem_din = l_wdata;
        end else begin
          l_rvalid_d = 1'b1;
          l_rdata_d  = mem_dout;
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_L;
      maddr_q    <= '0;
      mdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      l_rvalid_q <= l_rvalid_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign c_err    = c_err_q;
  assign c_rdata  = c_rdata_q;
  assign l_rvalid = l_rvalid_q;
  assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural word RAM (sync write,
// combinational read); inputs change on the falling edge.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [2:0]  c_funct3 = 3'b000;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic [31:0] ram [0:63] = '{default: 32'h0};
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign mem_dout = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_din;

  dmem_ctrl #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic set_c(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = d;
  endtask

  task automatic test_reset;
    set_c(1'b1, F3_W, 32'h10, 32'h1234_5678);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    total++; if (c_gnt !== 1'b0) $display("FAIL rst_c_gnt: got %b want 0", c_gnt); else passed++;
    total++; if (l_gnt !== 1'b0) $display("FAIL rst_l_gnt: got %b want 0", l_gnt); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_din !== 32'h0) $display("FAIL rst_mem_din: got %h want 0", mem_din); else passed++;
    total++; if ({c_rvalid, c_err, l_rvalid} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {c_rvalid, c_err, l_rvalid}); else passed++;
    total++; if ({c_rdata, l_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {c_rdata, l_rdata}); else passed++;
    c_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arbitration;
    logic exp_c;
    @(negedge clk);
    set_c(1'b0, F3_W, 32'h20, 32'h0);
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h24;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0);
      #1;
      total++; if ({c_gnt, l_gnt} !== {exp_c, ~exp_c}) $display("FAIL arb_cycle%0d: got c=%b l=%b want c=%b l=%b", i, c_gnt, l_gnt, exp_c, ~exp_c); else passed++;
      total++; if (mem_addr !== (exp_c ? 32'h20 : 32'h24)) $display("FAIL arb_addr%0d: got %h want %h", i, mem_addr, exp_c ? 32'h20 : 32'h24); else passed++;
      @(negedge clk);
    end
    c_req = 1'b0; l_req = 1'b0;
  endtask

  task automatic test_loader;
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h12; l_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if ({l_gnt, mem_we} !== 2'b11) $display("FAIL ldr_wr_gnt_we: got %b want 11", {l_gnt, mem_we}); else passed++;
    total++; if (mem_addr !== 32'h10) $display("FAIL ldr_wr_addr: got %h want 00000010", mem_addr); else passed++;
    total++; if (mem_din !== 32'hDEAD_BEEF) $display("FAIL ldr_wr_din: got %h want deadbeef", mem_din); else passed++;
    @(negedge clk);
    l_we = 1'b0; l_addr = 32'h10;
    #1;
    total++; if ({l_gnt, mem_we} !== 2'b10) $display("FAIL ldr_rd_gnt_we: got %b want 10", {l_gnt, mem_we}); else passed++;
    @(posedge clk); #1;
    l_req = 1'b0;
    total++; if (l_rvalid !== 1'b1) $display("FAIL ldr_rd_rvalid: got %b want 1", l_rvalid); else passed++;
    total++; if (l_rdata !== 32'hDEAD_BEEF) $display("FAIL ldr_rd_data: got %h want deadbeef", l_rdata); else passed++;
  endtask

  task automatic test_word_load;
    @(negedge clk);
    set_c(1'b0, F3_W, 32'h10, 32'h0);
    #1;
    total++; if ({c_gnt, mem_we} !== 2'b10) $display("FAIL lw_gnt_we: got %b want 10", {c_gnt, mem_we}); else passed++;
    total++; if (mem_addr !== 32'h10) $display("FAIL lw_addr: got %h want 00000010", mem_addr); else passed++;
    @(posedge clk); #1;
    c_req = 1'b0;
    total++; if ({c_rvalid, c_err} !== 2'b10) $display("FAIL lw_rvalid_err: got %b want 10", {c_rvalid, c_err}); else passed++;
    total++; if (c_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h want deadbeef", c_rdata); else passed++;
    @(posedge clk); #1;
    total++; if (c_rvalid !== 1'b0) $display("FAIL lw_rvalid_pulse: got %b want 0", c_rvalid); else passed++;
  endtask

  // Loads issued back to back; each grant overlaps the previous rvalid.
  task automatic test_extend_back_to_back;
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_c(1'b0, f3s[i], adrs[i], 32'h0);
      #1;
      total++; if (c_gnt !== 1'b1) $display("FAIL ext%0d_gnt: got %b want 1", i, c_gnt); else passed++;
      @(posedge clk); #1;
      total++; if ({c_rvalid, c_err} !== 2'b10) $display("FAIL ext%0d_rvalid_err: got %b want 10", i, {c_rvalid, c_err}); else passed++;
      total++; if (c_rdata !== exps[i]) $display("FAIL ext%0d_data: got %h want %h", i, c_rdata, exps[i]); else passed++;
    end
    c_req = 1'b0;
  endtask

  task automatic test_subword_store;
    logic [2:0]  f3s  [2] = '{F3_B, F3_H};
    logic [31:0] adrs [2] = '{32'h11, 32'h12};
    logic [31:0] wds  [2] = '{32'hABCD_EF55, 32'h9876_1234};
    logic [31:0] exps [2] = '{32'hDEAD_55EF, 32'h1234_55EF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_c(1'b1, f3s[i], adrs[i], wds[i]);
      #1;
      total++; if ({c_gnt, mem_we} !== 2'b10) $display("FAIL st%0d_grant_gnt_we: got %b want 10", i, {c_gnt, mem_we}); else passed++;
      total++; if (mem_addr !== 32'h10) $display("FAIL st%0d_grant_addr: got %h want 00000010", i, mem_addr); else passed++;
      @(posedge clk); #1;
      c_req = 1'b0;
      total++; if ({mem_we, c_rvalid} !== 2'b10) $display("FAIL st%0d_merge_we_rvalid: got %b want 10", i, {mem_we, c_rvalid}); else passed++;
      total++; if (mem_addr !== 32'h10) $display("FAIL st%0d_merge_addr: got %h want 00000010", i, mem_addr); else passed++;
      total++; if (mem_din !== exps[i]) $display("FAIL st%0d_merge_din: got %h want %h", i, mem_din, exps[i]); else passed++;
      @(posedge clk); #1;
      total++; if (mem_we !== 1'b0) $display("FAIL st%0d_done_we: got %b want 0", i, mem_we); else passed++;
      total++; if (ram[4] !== exps[i]) $display("FAIL st%0d_ram: got %h want %h", i, ram[4], exps[i]); else passed++;
    end
    @(negedge clk);
    set_c(1'b0, F3_W, 32'h10, 32'h0);
    @(posedge clk); #1;
    c_req = 1'b0;
    total++; if (c_rdata !== 32'h1234_55EF) $display("FAIL raw_data: got %h want 123455ef", c_rdata); else passed++;
  endtask

  task automatic test_store_blocks_loader;
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    @(posedge clk); #1;
    total++; if (l_rdata !== 32'h1234_55EF) $display("FAIL blk_pre_rdata: got %h want 123455ef", l_rdata); else passed++;
    @(negedge clk);
    set_c(1'b1, F3_B, 32'h14, 32'h0000_007F);
    #1;
    total++; if ({c_gnt, l_gnt} !== 2'b10) $display("FAIL blk_c0: got c=%b l=%b want c=1 l=0", c_gnt, l_gnt); else passed++;
    @(posedge clk); #1;
    c_req = 1'b0;
    @(negedge clk); #1;
    total++; if ({l_gnt, mem_we} !== 2'b01) $display("FAIL blk_merge_l_gnt_we: got %b want 01", {l_gnt, mem_we}); else passed++;
    total++; if ({mem_addr, mem_din} !== {32'h14, 32'h7F}) $display("FAIL blk_merge_bus: got %h/%h want 00000014/0000007f", mem_addr, mem_din); else passed++;
    @(negedge clk); #1;
    total++; if (l_gnt !== 1'b1) $display("FAIL blk_l_late_gnt: got %b want 1", l_gnt); else passed++;
    @(posedge clk); #1;
    l_req = 1'b0;
    total++; if ({l_rvalid, l_rdata} !== {1'b1, 32'h1234_55EF}) $display("FAIL blk_l_rdata: got %b/%h want 1/123455ef", l_rvalid, l_rdata); else passed++;
  endtask

  task automatic test_misaligned;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{F3_W, F3_H, 3'b011};
    logic [31:0] adrs [3] = '{32'h02, 32'h03, 32'h10};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_c(wes[i], f3s[i], adrs[i], 32'h0000_BEEF);
      #1;
      total++; if ({c_gnt, mem_we} !== 2'b10) $display("FAIL mis%0d_gnt_we: got %b want 10", i, {c_gnt, mem_we}); else passed++;
      @(posedge clk); #1;
      c_req = 1'b0;
      total++; if ({c_rvalid, c_err, mem_we} !== 3'b110) $display("FAIL mis%0d_rvalid_err_we: got %b want 110", i, {c_rvalid, c_err, mem_we}); else passed++;
      total++; if (c_rdata !== 32'h0) $display("FAIL mis%0d_rdata: got %h want 0", i, c_rdata); else passed++;
    end
    total++; if (ram[0] !== 32'h0) $display("FAIL mis_ram0: got %h want 0", ram[0]); else passed++;
  endtask

  task automatic test_reset_mid_merge;
    @(negedge clk);
    set_c(1'b1, F3_B, 32'h10, 32'h0000_00AA);
    @(posedge clk); #1;
    c_req = 1'b0;
    total++; if (mem_we !== 1'b1) $display("FAIL rmm_in_merge_we: got %b want 1", mem_we); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL rmm_async_we: got %b want 0", mem_we); else passed++;
    @(posedge clk); #1;
    total++; if (ram[4] !== 32'h1234_55EF) $display("FAIL rmm_ram: got %h want 123455ef", ram[4]); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if ({mem_we, c_rvalid} !== 2'b00) $display("FAIL rmm_after: got %b want 00", {mem_we, c_rvalid}); else passed++;
    total++; if (ram[4] !== 32'h1234_55EF) $display("FAIL rmm_ram_after: got %h want 123455ef", ram[4]); else passed++;
  endtask

  initial begin
    test_reset;
    test_arbitration;
    test_loader;
    test_word_load;
    test_extend_back_to_back;
    test_subword_store;
    test_store_blocks_loader;
    test_misaligned;
    test_reset_mid_merge;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
